// File: rtl/eth_rx_deser_if.sv
// RMII receive-side bundle: dibit/carrier inputs from the pins and the
// byte-strobe / frame-status outputs toward the rx packet consumer.
interface eth_rx_deser_if;
  logic [1:0]  Rxd;
  logic        Crs_Dv;
  logic [7:0]  Eth_Byte;
  logic        Eth_Byte_Valid;
  logic        Eth_Frame_Done;
  logic [10:0] Eth_Frame_Len;
  logic        Eth_Crc_Good;
  logic        Eth_Frame_Err;

  // Deserializer side: consumes the pins, produces the byte stream.
  modport slave (
    input  Rxd,
    input  Crs_Dv,
    output Eth_Byte,
    output Eth_Byte_Valid,
    output Eth_Frame_Done,
    output Eth_Frame_Len,
    output Eth_Crc_Good,
    output Eth_Frame_Err
  );

  // PHY/consumer side: drives the pins, observes the byte stream.
  modport master (
    output Rxd,
    output Crs_Dv,
    input  Eth_Byte,
    input  Eth_Byte_Valid,
    input  Eth_Frame_Done,
    input  Eth_Frame_Len,
    input  Eth_Crc_Good,
    input  Eth_Frame_Err
  );
endinterface

// File: rtl/eth_rx_deser.sv
// RMII receive deserializer: preamble/SFD detection, LSB-first dibit to byte
// assembly, running CRC-32 residue check and per-frame status pulse.
module eth_rx_deser #(
  parameter int MIN_PREAMBLE_DIBITS = 4,
  parameter int MIN_BYTES           = 64,
  parameter int MAX_BYTES           = 1522
) (
  input  logic            Clk,
  input  logic            Rst,
  eth_rx_deser_if.slave   bus
);

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  // One spare bit so the saturating count can always reach the threshold.
  localparam int          PW          = $clog2(MIN_PREAMBLE_DIBITS + 1) + 1;
  localparam logic [PW-1:0] PRE_MIN   = PW'(MIN_PREAMBLE_DIBITS);
  localparam logic [PW-1:0] PRE_SAT   = {PW{1'b1}};
  localparam logic [10:0] LEN_SAT     = 11'h7FF;
  localparam logic [10:0] LEN_MIN     = 11'(MIN_BYTES);
  localparam logic [10:0] LEN_MAX     = 11'(MAX_BYTES);

  typedef enum logic [2:0] {
    ST_DROP,
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_END
  } state_t;

  state_t        state_q;
  logic [PW-1:0] pre_cnt_q;
  logic [1:0]    idx_q;
  logic [7:0]    shift_q;
  logic [10:0]   len_q;
  logic [31:0]   crc_q;
  logic [31:0]   crc_d;

  logic [7:0]    byte_q;
  logic          byte_valid_q;
  logic          done_q;
  logic [10:0]   frame_len_q;
  logic          crc_good_q;
  logic          frame_err_q;

  // One bit-serial step of the reflected CRC-32.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
    crc_step = (c >> 1) ^ (((c[0] ^ b) == 1'b1) ? CRC_POLY : 32'h0);
  endfunction

  // CRC after absorbing this cycle's dibit, earlier bit Rxd[0] first.
  always_comb begin
    crc_d = crc_step(crc_step(crc_q, bus.Rxd[0]), bus.Rxd[1]);
  end

  // Frame FSM with all outputs registered; strobes default low every cycle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= ST_DROP;
      pre_cnt_q    <= '0;
      idx_q        <= 2'd0;
      shift_q      <= 8'h00;
      len_q        <= 11'd0;
      crc_q        <= CRC_INIT;
      byte_q       <= 8'h00;
      byte_valid_q <= 1'b0;
      done_q       <= 1'b0;
      frame_len_q  <= 11'd0;
      crc_good_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      done_q       <= 1'b0;
      unique case (state_q)
        // Wait out the rest of a rejected or interrupted carrier.
        ST_DROP: begin
          if (!bus.Crs_Dv) state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          if (bus.Crs_Dv) begin
            if (bus.Rxd == 2'b01) begin
              state_q   <= ST_PREAMBLE;
              pre_cnt_q <= PW'(1);
            end else if (bus.Rxd[1]) begin
              state_q <= ST_DROP;
            end
          end
        end
        ST_PREAMBLE: begin
          if (!bus.Crs_Dv) begin
            state_q <= ST_IDLE;
          end else begin
            case (bus.Rxd)
              2'b01: begin
                if (pre_cnt_q != PRE_SAT) pre_cnt_q <= pre_cnt_q + PW'(1);
              end
              2'b11: begin
                if (pre_cnt_q >= PRE_MIN) begin
                  state_q <= ST_DATA;
                  crc_q   <= CRC_INIT;
                  idx_q   <= 2'd0;
                  len_q   <= 11'd0;
                end else begin
                  state_q <= ST_DROP;
                end
              end
              default: state_q <= ST_DROP;
            endcase
          end
        end
        ST_DATA: begin
          if (bus.Crs_Dv) begin
            shift_q[{idx_q, 1'b0} +: 2] <= bus.Rxd;
            crc_q <= crc_d;
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              // Oversize bytes still count toward the length but are not shown.
              if (len_q < LEN_MAX) begin
                byte_q       <= {bus.Rxd, shift_q[5:0]};
                byte_valid_q <= 1'b1;
              end
              if (len_q != LEN_SAT) len_q <= len_q + 11'd1;
            end
          end else begin
            // Carrier gone: status is latched now so Done lands in END.
            state_q     <= ST_END;
            done_q      <= 1'b1;
            frame_len_q <= len_q;
            crc_good_q  <= (crc_q == CRC_RESIDUE);
            frame_err_q <= (idx_q != 2'd0) || (len_q < LEN_MIN) || (len_q > LEN_MAX);
          end
        end
        // The END cycle absorbs the one-cycle interframe gap.
        ST_END: begin
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_DROP;
      endcase
    end
  end

  assign bus.Eth_Byte       = byte_q;
  assign bus.Eth_Byte_Valid = byte_valid_q;
  assign bus.Eth_Frame_Done = done_q;
  assign bus.Eth_Frame_Len  = frame_len_q;
  assign bus.Eth_Crc_Good   = crc_good_q;
  assign bus.Eth_Frame_Err  = frame_err_q;

endmodule

// File: doc/eth_rx_deser.md
Name: eth_rx_deser

Overview:
- RMII receive deserializer: the receive-side counterpart of the eth_tx byte-to-dibit serializer.
- Detects preamble and SFD on the 2-bit Rxd/Crs_Dv stream, assembles LSB-first dibits into bytes, and emits a byte-strobe stream.
- At frame end, issues a one-cycle frame-done pulse carrying length, CRC-32 residue check and error status.
- Sits in the Eth_Clk domain between the RMII pins and the rx packet consumer.

Parameters:
- MIN_PREAMBLE_DIBITS, 4, minimum count of 2'b01 dibits required before the SFD dibit 2'b11.
- MIN_BYTES, 64, frames shorter than this (FCS included) flag Eth_Frame_Err.
- MAX_BYTES, 1522, bytes beyond this are not output; frame flags Eth_Frame_Err.

Ports:
- Clk  input  1  Eth_Clk, 50 MHz RMII reference; one dibit per cycle.
- Rst  input  1  synchronous, active-high reset.
- Rxd  input  2  RMII receive dibit; Rxd[0] is the earlier bit.
- Crs_Dv  input  1  carrier/data valid; treated as a pure data-valid qualifier.
- Eth_Byte  output  8  assembled byte; [1:0] is the first dibit received.
- Eth_Byte_Valid  output  1  one-cycle strobe per assembled byte.
- Eth_Frame_Done  output  1  one-cycle pulse at frame end.
- Eth_Frame_Len  output  11  byte count incl. FCS, saturating at 2047; held until next Done.
- Eth_Crc_Good  output  1  CRC residue matched; held until next Done.
- Eth_Frame_Err  output  1  alignment/runt/oversize error; held until next Done.

Behaviour:
- Interface: one clock (Clk); reset Rst is synchronous and active-high.
- Reset: all outputs 0, byte/dibit counters 0, CRC register 0xFFFFFFFF, state DROP.
  - Reset mid-frame therefore discards the remainder of the carrier.
- States:
  - DROP: Crs_Dv low -> IDLE.
  - IDLE:
    - Crs_Dv low or Rxd==00 -> stay.
    - Crs_Dv high & Rxd==01 -> PREAMBLE, preamble count=1.
    - Crs_Dv high & Rxd==10 or 11 -> DROP.
  - PREAMBLE:
    - Crs_Dv low -> IDLE.
    - Rxd==01 -> count+1, saturating.
    - Rxd==11 & count>=MIN_PREAMBLE_DIBITS -> DATA; CRC=0xFFFFFFFF, dibit idx=0, len=0.
    - Rxd==11 & count too low, or Rxd==00/10 -> DROP.
    - No Done is ever issued from PREAMBLE or IDLE.
  - DATA: each Crs_Dv-high cycle shifts Rxd into a byte shift register at position idx, updates CRC, and increments idx mod 4.
    - Byte complete (idx==3 sampled): Eth_Byte/Eth_Byte_Valid asserted the next cycle; len+1, saturating at 2047.
    - If len already >= MAX_BYTES, the byte is counted but not strobed.
    - Crs_Dv low -> END.
  - END (single cycle): Eth_Frame_Done=1; then -> IDLE.
    - Eth_Frame_Len = len.
    - Eth_Crc_Good = (CRC == 0xDEBB20E3).
    - Eth_Frame_Err = (idx!=0) | (len<MIN_BYTES) | (len>MAX_BYTES).
- CRC: reflected CRC-32, polynomial 0xEDB88320, two bit-serial steps per cycle (Rxd[0] then Rxd[1]), computed over all bytes incl. FCS, no final inversion.
  - Partial trailing dibits are included in the CRC; they are flagged by the alignment error.
- Latency: last dibit of a byte sampled at cycle N -> Eth_Byte_Valid at N+1.
  - Crs_Dv first sampled low at cycle M -> Eth_Frame_Done at M+1.
- Eth_Byte holds its last value between strobes.
- Back-to-back frames: a new preamble may begin the cycle after END.
  - The minimum interframe gap (Crs_Dv low) is 1 cycle, consumed by END.

Test Plan:
- 64-byte frame (7×0x55, 0xD5, 60 bytes 0x01..0x3C, valid FCS) -> 64 strobes in order, 4 cycles apart; Done with Len=64, Crc_Good=1, Err=0.
- Same frame with bit 3 of byte 10 flipped -> bytes match the flipped stream, Len=64, Crc_Good=0, Err=0.
- Crs_Dv dropped 2 dibits into byte 65 -> 64 strobes; Done with Len=64, Err=1 (alignment).
- 1600-byte frame, MAX_BYTES=1522 -> exactly 1522 strobes; Done with Len=1600, Err=1. Separately, 30-byte frame -> Len=30, Err=1 (runt).
- Preamble of only 2×01 then 11, followed by 64 bytes -> DROP: no strobes, no Done; next well-formed frame after Crs_Dv low is received correctly.
- Rst pulsed at byte 20 of a frame -> outputs 0 the next cycle, no strobes or Done for the rest of that carrier; the following frame gives Len=64, Crc_Good=1.
